// File: rtl/sample_pkg.sv
// Shared definitions for the sample narrowing block: counter width and
// two's-complement range helpers used by the saturation stage.
package sample_pkg;

    localparam int SAT_CNT_W = 16;

    function automatic logic signed [31:0] sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/saturate.sv
// Combinational clip of a signed IN_W-bit value into the signed OUT_W-bit range.
// o_sat flags that the value was replaced by a range limit.
module saturate
    import sample_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    localparam logic signed [31:0] MAX = sat_max(OUT_W);
    localparam logic signed [31:0] MIN = sat_min(OUT_W);

    logic signed [31:0] w_ext;

    assign w_ext = 32'(signed'(i_data));

    always_comb begin
        o_sat  = 1'b0;
        o_data = i_data[OUT_W-1:0];
        if (w_ext > MAX) begin
            o_sat  = 1'b1;
            o_data = MAX[OUT_W-1:0];
        end else if (w_ext < MIN) begin
            o_sat  = 1'b1;
            o_data = MIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/sample_narrow.sv
// Two-stage round-half-up and saturate narrowing pipeline with valid/ready on both sides.
// Define SAMPLE_NARROW_SATCNT_EN to build the saturation event counter on sat_count.
module sample_narrow
    import sample_pkg::*;
#(
    parameter int LENGTH_IN  = 20,
    parameter int LENGTH_OUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LENGTH_IN-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LENGTH_OUT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag,
    output logic [SAT_CNT_W-1:0]  sat_count
);

    localparam int D  = LENGTH_IN - LENGTH_OUT;
    localparam int RW = LENGTH_OUT + 1;
    localparam logic [LENGTH_IN:0] HALF = (LENGTH_IN + 1)'(1) << (D - 1);

    logic [LENGTH_IN:0]  w_ext;
    logic [LENGTH_IN:0]  w_sum;
    logic [RW-1:0]       w_rnd;
    logic [LENGTH_OUT-1:0] w_sat_data;
    logic                w_sat;
    logic                w_adv1;
    logic                w_adv2;

    logic                r_s1_valid;
    logic [RW-1:0]       r_s1_data;
    logic                r_s2_valid;
    logic [LENGTH_OUT-1:0] r_out_data;
    logic                r_sat_flag;

    // Sign extension by one bit keeps the +half addition from overflowing.
    assign w_ext = {in_data[LENGTH_IN-1], in_data};
    assign w_sum = w_ext + HALF;
    assign w_rnd = RW'(w_sum >> D);

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= w_rnd;
            end
        end
    end

    saturate #(
        .IN_W  (RW),
        .OUT_W (LENGTH_OUT)
    ) u_saturate (
        .i_data (r_s1_data),
        .o_data (w_sat_data),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_sat_flag <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_sat_data;
                r_sat_flag <= w_sat;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;

`ifdef SAMPLE_NARROW_SATCNT_EN
    logic [SAT_CNT_W-1:0] r_sat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (r_s2_valid && out_ready && r_sat_flag && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

endmodule

// File: doc/sample_narrow.md
SAMPLE_NARROW -- requirements
Module: sample_narrow

Interface
REQ-001 SHALL have parameter LENGTH_IN, default 20, input sample width in bits (two's complement).
REQ-002 SHALL have parameter LENGTH_OUT, default 16, output sample width in bits; LENGTH_OUT < LENGTH_IN is required.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  LENGTH_IN  signed input sample.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  LENGTH_OUT  rounded, saturated sample.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port sat_flag  output  1  out_data was clipped; qualified by out_valid.
REQ-012 SHALL have port sat_count  output  16  saturation event count (SAMPLE_NARROW_SATCNT_EN only).

Function
REQ-013 SHALL define D = LENGTH_IN - LENGTH_OUT as the number of dropped LSBs.
REQ-014 SHALL round half up: sign-extend in_data to LENGTH_IN+1 bits, add 2^(D-1), arithmetic shift right by D.
REQ-015 SHALL saturate the rounded value to [-2^(LENGTH_OUT-1), 2^(LENGTH_OUT-1)-1], setting sat_flag for that sample when clipped.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers the rounded value; stage 2 registers saturated out_data and sat_flag.
REQ-017 SHALL transfer a beat when valid and ready are both high on a clock edge, on each side.
REQ-018 SHALL have a latency of 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-019 SHALL sustain one sample per cycle under continuous in_valid and out_ready.
REQ-020 SHALL advance stage 2 when !out_valid or out_ready; stage 1 advances when stage 1 is empty or stage 2 advances; in_ready equals the stage-1 advance condition.
REQ-021 SHALL hold out_data, sat_flag and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL lose and duplicate no samples across any stall pattern, including simultaneous input transfer and output stall.
REQ-023 SHALL not combinationally depend in_ready on in_valid.

Reset
REQ-024 SHALL on rst_n low asynchronously clear both stage valid bits, out_valid=0, out_data=0, sat_flag=0, sat_count=0.
REQ-025 SHALL drive in_ready=1 during and after reset.
REQ-026 SHALL discard in-flight samples on reset mid-stream; the first post-reset output is the first post-reset input.

Configuration
REQ-027 SHALL, with SAMPLE_NARROW_SATCNT_EN defined, increment sat_count on each output transfer with sat_flag=1, saturating at 0xFFFF.
REQ-028 SHALL, without SAMPLE_NARROW_SATCNT_EN, omit the counter and tie sat_count to 0.

Structure
REQ-029 SHALL place the sat_count width (16) and the saturation min/max helper functions in the shared package sample_pkg.
REQ-030 SHALL implement stage-2 clipping as one sub-module, saturate, combinational, parameterised by input and output widths.

Verification (LENGTH_IN=20, LENGTH_OUT=16, D=4)
REQ-031 SHALL cover rounding: in 0x00018 -> out 0x0002, sat_flag=0; in 0xFFFF8 -> out 0x0000; in 0xFFFF7 -> out 0xFFFF.
REQ-032 SHALL cover positive clip: in 0x7FFFF -> out 0x7FFF, sat_flag=1, sat_count 0->1 (macro defined).
REQ-033 SHALL cover the negative limit: in 0x80000 -> out 0x8000, sat_flag=0, sat_count unchanged.
REQ-034 SHALL cover back-pressure: stream 8 ramp samples with out_ready low for 3 cycles mid-stream -> all 8 outputs in order, out_data stable while stalled, in_ready low once both stages are full.
REQ-035 SHALL cover throughput: 100 consecutive samples with out_ready=1 -> first out_valid 2 cycles after the first transfer, 100 outputs in 100 cycles.
REQ-036 SHALL cover reset mid-stream: rst_n low with 2 samples in flight -> out_valid=0 immediately, no stale outputs after release.
